// File: rtl/dpr_pkg.sv
// Shared widths and reader state encoding for the dual-port RAM burst reader.
package dpr_pkg;
  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 10;
  localparam int MEM_DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;
endpackage

// File: rtl/dpr_burst_reader_fifo2.sv
// Two-entry synchronous FIFO; the head is valid whenever count_o is non-zero.
module dpr_fifo2
  import dpr_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] head_o,
  output logic [1:0]   count_o
);
  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) rd_ptr_q <= ~rd_ptr_q;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/dpr_burst_reader.sv
// Streams len consecutive RAM words from start_addr onto a valid/ready port.
// Reads are throttled so that FIFO occupancy plus the in-flight read never exceeds two.
module dpr_burst_reader
  import dpr_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic [ADDR_W:0]   len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              mem_rd_en_o,
  output logic              mem_blk_select_o,
  output logic [ADDR_W-1:0] mem_addr_rd_o,
  input  logic [DATA_W-1:0] mem_dout_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_valid_o,
  input  logic              m_ready_i
);
  rd_state_e         state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_hold_q;
  logic [ADDR_W:0]   rem_q;
  logic              inflight_q;
  logic              done_q;

  logic [1:0] count;
  logic       pop;
  logic       issue;
  logic [2:0] occ;

  assign pop   = m_valid_o & m_ready_i;
  assign occ   = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue = (state_q == RUN) && (rem_q != '0) && (occ < 3'd2);

  dpr_fifo2 #(.W(DATA_W)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (inflight_q),
    .pop_i   (pop),
    .din_i   (mem_dout_i),
    .head_o  (m_data_o),
    .count_o (count)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      addr_hold_q <= '0;
      rem_q       <= '0;
      inflight_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      inflight_q <= issue;
      if (issue) begin
        addr_q      <= addr_q + ADDR_W'(1);
        addr_hold_q <= addr_q;
        rem_q       <= rem_q - (ADDR_W + 1)'(1);
      end
      case (state_q)
        IDLE: begin
          if (start_i) begin
            if (len_i != '0) begin
              addr_q  <= start_addr_i;
              rem_q   <= len_i;
              state_q <= RUN;
            end else begin
              state_q <= DRAIN;
            end
          end
        end
        RUN: begin
          if (issue && rem_q == (ADDR_W + 1)'(1)) state_q <= DRAIN;
        end
        DRAIN: begin
          // Look ahead one edge so done lands the cycle after the last transfer.
          if (!inflight_q && (count == 2'd0 || (count == 2'd1 && pop))) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o           = (state_q != IDLE);
  assign done_o           = done_q;
  assign mem_rd_en_o      = issue;
  assign mem_blk_select_o = issue;
  assign mem_addr_rd_o    = (state_q == RUN) ? addr_q : addr_hold_q;
  assign m_valid_o        = (count != 2'd0);
endmodule

// File: tb/tb_dpr_burst_reader.sv
// Bench for dpr_burst_reader: a RAM model feeds the DUT and a scoreboard checks the stream.
module tb_dpr_burst_reader;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  start_addr;
  logic [10:0] len;
  logic        busy, done, mem_rd_en, mem_blk_select, m_valid, m_ready;
  logic [9:0]  mem_addr_rd;
  logic [15:0] mem_dout, m_data;
  logic [15:0] ram [1024];

  int vecs = 0;
  int miss = 0;

  typedef struct {
    int addr;
    int n;
    int mode;
    int exp_first;
    int exp_done;
  } vec_t;

  vec_t tbl [5];

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_rd_en && mem_blk_select) mem_dout <= ram[mem_addr_rd];

  dpr_burst_reader dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .start_i          (start),
    .start_addr_i     (start_addr),
    .len_i            (len),
    .busy_o           (busy),
    .done_o           (done),
    .mem_rd_en_o      (mem_rd_en),
    .mem_blk_select_o (mem_blk_select),
    .mem_addr_rd_o    (mem_addr_rd),
    .mem_dout_i       (mem_dout),
    .m_data_o         (m_data),
    .m_valid_o        (m_valid),
    .m_ready_i        (m_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic ready_for(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return (cyc <= 6) ? 1'b0 : cyc[0];
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rd_en"}, mem_rd_en, 0);
    chk({tag, "_blk_sel"}, mem_blk_select, 0);
    chk({tag, "_addr"}, mem_addr_rd, 0);
    chk({tag, "_valid"}, m_valid, 0);
    chk({tag, "_data"}, m_data, 0);
  endtask

  // Cycle cyc counts samples after the edge that accepted start.
  task automatic run_burst(input int a, input int n, input int mode,
                           output int first_cyc, output int done_cyc);
    int issued, xfers, exp_done_cyc, limit, cyc;
    logic stalled;
    logic [15:0] held;
    issued = 0; xfers = 0; first_cyc = 0; done_cyc = 0;
    stalled = 1'b0; held = '0;
    exp_done_cyc = (n == 0) ? 2 : -1;
    limit = n * 8 + 40;
    @(negedge clk);
    start = 1'b1; start_addr = a[9:0]; len = n[10:0]; m_ready = 1'b0;
    for (cyc = 1; cyc <= limit; cyc++) begin
      @(negedge clk);
      start   = 1'b0;
      m_ready = ready_for(mode, cyc);
      #1;
      if (stalled) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, held);
      end
      if (mem_blk_select !== mem_rd_en) chk("blk_sel", mem_blk_select, mem_rd_en);
      if (mem_rd_en) begin
        chk("rd_addr", mem_addr_rd, (a + issued) % 1024);
        chk("outstanding_le2",
            32'((issued + 1 - xfers - ((m_valid && m_ready) ? 1 : 0)) <= 2), 1);
        issued++;
      end
      if (m_valid && first_cyc == 0) first_cyc = cyc;
      if (m_valid && m_ready) begin
        chk("data", m_data, ram[(a + xfers) % 1024]);
        xfers++;
        if (xfers == n) exp_done_cyc = cyc + 1;
      end
      stalled = m_valid && !m_ready;
      held    = m_data;
      if (done || cyc == exp_done_cyc) chk("done", done, 32'(cyc == exp_done_cyc));
      if (busy !== (exp_done_cyc < 0 || cyc < exp_done_cyc))
        chk("busy", busy, 32'(exp_done_cyc < 0 || cyc < exp_done_cyc));
      if (done && done_cyc == 0) done_cyc = cyc;
      if (cyc == exp_done_cyc) break;
    end
    if (cyc > limit) chk("timeout", 0, 1);
    chk("issued", issued, n);
    chk("xfers", xfers, n);
    @(negedge clk);
    #1;
    chk("done_once", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    int fc, dc, xf, a, n;
    tbl[0] = '{addr: 0,    n: 4,    mode: 0, exp_first: 3, exp_done: 7};
    tbl[1] = '{addr: 1022, n: 4,    mode: 0, exp_first: 3, exp_done: 7};
    tbl[2] = '{addr: 0,    n: 8,    mode: 1, exp_first: 3, exp_done: -1};
    tbl[3] = '{addr: 0,    n: 0,    mode: 0, exp_first: 0, exp_done: 2};
    tbl[4] = '{addr: 0,    n: 1024, mode: 0, exp_first: 3, exp_done: 1027};

    for (int i = 0; i < 1024; i++) ram[i] = 16'(i);
    rst = 1'b1; start = 1'b0; start_addr = '0; len = '0; m_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_idle_outputs("reset");
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_burst(tbl[i].addr, tbl[i].n, tbl[i].mode, fc, dc);
      chk("first_valid_cyc", fc, tbl[i].exp_first);
      if (tbl[i].exp_done >= 0) chk("done_cyc", dc, tbl[i].exp_done);
    end

    // Second start mid-burst must be ignored; reset mid-burst must clear everything.
    @(negedge clk);
    start = 1'b1; start_addr = '0; len = 11'd16; m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    xf = 0;
    for (int c = 0; c < 60 && xf < 8; c++) begin
      #1;
      if (m_valid && m_ready) begin
        chk("ign_start_data", m_data, ram[xf]);
        xf++;
        if (xf == 5) begin
          start = 1'b1; start_addr = 10'd500; len = 11'd3;
        end
      end
      @(negedge clk);
      start = 1'b0;
    end
    chk("ign_start_words", xf, 8);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_idle_outputs("midrst");
    run_burst(100, 2, 0, fc, dc);
    chk("after_rst_done_cyc", dc, 5);

    for (int i = 0; i < 1024; i++) ram[i] = 16'($urandom);
    for (int k = 0; k < 20; k++) begin
      a = $urandom_range(0, 1023);
      n = $urandom_range(0, 40);
      run_burst(a, n, 2, fc, dc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule

// File: doc/dpr_burst_reader.md
Name: dpr_burst_reader

Overview:
- Read-side master for the synchronous dual-port RAM (dpr_sync): on a start command it streams LEN consecutive words out of the RAM's read port, starting at START_ADDR.
- Data is delivered on a valid/ready stream with full backpressure support.
- Sits between the RAM read port and downstream consumers (checkers, UART/SPI transmitters). Write-side agents keep exclusive use of the RAM write port.

Parameters:
- DATA_W, 16, RAM word width.
- ADDR_W, 10, RAM address width; depth = 2**ADDR_W = 1024.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  command strobe; sampled only in IDLE.
- start_addr  in  ADDR_W  first word address.
- len  in  ADDR_W+1  word count, 0..1024.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- mem_rd_en  out  1  RAM read enable.
- mem_blk_select  out  1  RAM block select; always equal to mem_rd_en.
- mem_addr_rd  out  ADDR_W  RAM read address.
- mem_dout  in  DATA_W  RAM registered read data; valid one cycle after mem_rd_en.
- m_data  out  DATA_W  stream data.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready; a transfer occurs when m_valid and m_ready are both high.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, busy=0, done=0, mem_rd_en=0, mem_blk_select=0, mem_addr_rd=0, m_valid=0, m_data=0. The FIFO is flushed and any in-flight read is discarded. This applies equally when rst is asserted mid-burst.
- FSM states are IDLE, RUN and DRAIN.
  - IDLE: start=1 with len>0 latches addr=start_addr and remaining=len, then moves to RUN. start=1 with len=0 moves straight to DRAIN (no reads issued).
  - RUN: issue reads while remaining>0; go to DRAIN when the last read is issued.
  - DRAIN: when inflight=0, the FIFO is empty and no pop is pending, pulse done for one cycle and return to IDLE.
- start is ignored while busy=1.
- Read issue (combinational): mem_rd_en = RUN & remaining>0 & (count + inflight - pop) < 2, where:
  - count = FIFO occupancy (0..2);
  - inflight = a read was issued on the previous edge;
  - pop = m_valid & m_ready.
- On each issue edge: addr increments modulo 2**ADDR_W (1023 wraps to 0), remaining decrements, inflight is set.
- mem_addr_rd = addr in RUN, and holds its last value otherwise.
- Capture: when inflight=1, mem_dout is written into the 2-entry FIFO at the next edge. With the issue rule above, overflow is impossible.
- Stream output:
  - m_valid = FIFO non-empty; m_data = FIFO head.
  - m_data must stay stable while m_valid=1 and m_ready=0.
- Latency: start is sampled at edge E0, mem_rd_en is high after E0, and m_valid first rises after E2. With m_ready held at 1, throughput is one word per cycle.
- done timing: asserted for one cycle, the cycle after the final transfer. For len=0, done is asserted the cycle after start is sampled.
- busy equals (state != IDLE). busy drops in the same cycle that done is asserted.
- Simultaneous FIFO push and pop is legal; count is unchanged.

Decomposition:
- Package dpr_pkg holds DATA_W, ADDR_W, MEM_DEPTH and the reader state enum (IDLE/RUN/DRAIN).
- One sub-module, dpr_fifo2: a 2-entry synchronous FIFO with push/pop/count/head outputs and synchronous active-high reset.

Test Plan:
- Backdoor-load mem[i]=i. Command start_addr=0, len=4, m_ready=1. Expect mem_addr_rd=0,1,2,3 on consecutive cycles and m_data=0,1,2,3 on consecutive cycles, with first m_valid 2 cycles after start. Expect one done pulse the cycle after the word 3 transfer.
- Command start_addr=1022, len=4. Expect read addresses 1022,1023,0,1 and m_data=1022,1023,0,1 (wrap-around).
- Command len=8 with m_ready=0 for 6 cycles, then toggling 1/0. Expect at most 2 reads issued before any transfer, m_data held stable while stalled, and all 8 words delivered in order with none lost or duplicated.
- Command len=0. Expect mem_rd_en never asserted, m_valid never asserted, and done high for exactly the 1 cycle after start.
- Start a burst with len=16. Pulse start again at word 5 and expect it to be ignored. Assert rst at word 8 and expect all outputs 0 the next cycle. Then issue start_addr=100, len=2 and expect m_data=100,101.
- Command start_addr=0, len=1024 with m_ready=1. Expect 1024 transfers on consecutive cycles, done after the word 1023 transfer, and busy low afterwards.
